mii_rx_checker: RTL and testbench

- Downstream consumer of the 1.6TMII character generator. Takes its data/ctrl/tx_en/tx_er stream and checks each octet lane against the expected data or control pattern.
- Keeps saturating per-character and per-cycle statistics in hardware, so benches and the eventual receive path stop counting in testbench loops.
- Runs a link-health state machine that flags sustained error bursts.

---
 rtl/mii_rx_checker_if.sv | 14 +
 rtl/mii_rx_checker.sv | 141 ++++++++++++++
 tb/tb_mii_rx_checker.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_rx_checker_if.sv
// rtl/mii_rx_checker_if.sv - 1.6TMII character stream bundle (data/ctrl/tx_en/tx_er)
interface mii_rx_checker_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] data_in;
    logic [LANES-1:0]      ctrl_in;
    logic                  tx_en;
    logic                  tx_er;

    modport master (output data_in, ctrl_in, tx_en, tx_er);
    modport slave  (input  data_in, ctrl_in, tx_en, tx_er);
endinterface

// File: rtl/mii_rx_checker.sv
// rtl/mii_rx_checker.sv - per-lane pattern checker with saturating stats and link-health FSM
module mii_rx_checker #(
    parameter int         DATA_WIDTH        = 64,
    parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
    parameter logic [7:0] CTRL_CHAR_PATTERN = 8'h55,
    parameter int         CNT_WIDTH         = 32,
    parameter int         ERR_RUN_LIMIT     = 4,
    parameter int         GOOD_RUN_LIMIT    = 8,
    localparam int        LANES             = DATA_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mii_rx_checker_if.slave      rx,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] data_cnt,
    output logic [CNT_WIDTH-1:0] ctrl_cnt,
    output logic [CNT_WIDTH-1:0] txer_cnt,
    output logic [CNT_WIDTH-1:0] mism_cnt,
    output logic [CNT_WIDTH-1:0] valid_cyc_cnt,
    output logic [LANES-1:0]     lane_mism,
    output logic [1:0]           link_state,
    output logic                 fault
);
    // One spare bit keeps the popcount and run widths non-degenerate for tiny parameters.
    localparam int PCW = $clog2(LANES + 1) + 1;
    localparam int ERW = $clog2(ERR_RUN_LIMIT + 1) + 1;
    localparam int GRW = $clog2(GOOD_RUN_LIMIT + 1) + 1;
    localparam logic [PCW-1:0] LANES_PC = PCW'(LANES);
    localparam logic [ERW-1:0] ERR_LIM  = ERW'(ERR_RUN_LIMIT);
    localparam logic [GRW-1:0] GOOD_LIM = GRW'(GOOD_RUN_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    logic [DATA_WIDTH-1:0] s1_data;
    logic [LANES-1:0]      s1_ctrl;
    logic                  s1_valid;
    logic                  s1_er;

    logic [LANES-1:0] mism;
    logic [PCW-1:0]   ctrl_pc, mism_pc;
    logic             bad, good, err_hit, good_hit;
    logic [ERW-1:0]   err_run, err_run_inc, err_run_nxt;
    logic [GRW-1:0]   good_run, good_run_inc, good_run_nxt;
    state_e           state, state_nxt;

    function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int j = 0; j < LANES; j++) c = c + PCW'(v[j]);
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [PCW-1:0]       b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH + 1 - PCW){1'b0}}, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Stage 1: clear only kills the valid bit so the in-flight cycle is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_ctrl  <= '0;
            s1_valid <= 1'b0;
            s1_er    <= 1'b0;
        end else begin
            s1_data  <= rx.data_in;
            s1_ctrl  <= rx.ctrl_in;
            s1_valid <= clear ? 1'b0 : rx.tx_en;
            s1_er    <= rx.tx_er;
        end
    end

    always_comb begin
        mism = '0;
        for (int j = 0; j < LANES; j++) begin
            mism[j] = s1_ctrl[j] ? (s1_data[8*j +: 8] != CTRL_CHAR_PATTERN)
                                 : (s1_data[8*j +: 8] != DATA_CHAR_PATTERN);
        end
    end

    assign ctrl_pc      = popcount(s1_ctrl);
    assign mism_pc      = popcount(mism);
    assign bad          = s1_valid && (s1_er || (|mism));
    assign good         = s1_valid && !bad;
    assign err_run_inc  = err_run + ERW'(1);
    assign good_run_inc = good_run + GRW'(1);
    assign err_hit      = bad && (err_run_inc >= ERR_LIM);
    assign good_hit     = good && (good_run_inc >= GOOD_LIM);
    assign err_run_nxt  = bad ? (err_hit ? ERR_LIM : err_run_inc) : '0;
    assign good_run_nxt = good ? (good_hit ? GOOD_LIM : good_run_inc) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (s1_valid) state_nxt = err_hit ? ST_FAULT : ST_RUN;
            ST_RUN:   if (err_hit) state_nxt = ST_FAULT;
                      else if (!s1_valid) state_nxt = ST_IDLE;
            ST_FAULT: if (good_hit) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= ST_IDLE;
            err_run  <= '0;
            good_run <= '0;
        end else begin
            state    <= state_nxt;
            err_run  <= err_run_nxt;
            good_run <= good_run_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data_cnt      <= '0;
            ctrl_cnt      <= '0;
            txer_cnt      <= '0;
            mism_cnt      <= '0;
            valid_cyc_cnt <= '0;
            lane_mism     <= '0;
        end else begin
            data_cnt      <= sat_add(data_cnt, s1_valid ? (LANES_PC - ctrl_pc) : '0);
            ctrl_cnt      <= sat_add(ctrl_cnt, s1_valid ? ctrl_pc : '0);
            mism_cnt      <= sat_add(mism_cnt, s1_valid ? mism_pc : '0);
            valid_cyc_cnt <= sat_add(valid_cyc_cnt, PCW'(s1_valid));
            txer_cnt      <= sat_add(txer_cnt, PCW'(s1_er));
            lane_mism     <= s1_valid ? mism : '0;
        end
    end

    assign link_state = state;
    assign fault      = (state == ST_FAULT);
endmodule

// File: tb/tb_mii_rx_checker.sv
// tb/tb_mii_rx_checker.sv - table, hand-sequence and randomized checks against a reference model
module tb_mii_rx_checker;
    localparam logic [63:0] PAT_A  = 64'hAAAAAAAA55555555;
    localparam logic [63:0] ALL_AA = {8{8'hAA}};
    localparam int ELIM = 4;
    localparam int GLIM = 8;

    logic clk, rst, clear;
    mii_rx_checker_if #(.DATA_WIDTH(64)) rx ();

    logic [31:0] a_data, a_ctrl, a_txer, a_mism, a_valid;
    logic [7:0]  b_data, b_ctrl, b_txer, b_mism, b_valid;
    logic [7:0]  a_lm, b_lm;
    logic [1:0]  a_ls, b_ls;
    logic        a_fault, b_fault;

    mii_rx_checker dut_a (
        .clk(clk), .rst(rst), .rx(rx.slave), .clear(clear),
        .data_cnt(a_data), .ctrl_cnt(a_ctrl), .txer_cnt(a_txer), .mism_cnt(a_mism),
        .valid_cyc_cnt(a_valid), .lane_mism(a_lm), .link_state(a_ls), .fault(a_fault)
    );

    mii_rx_checker #(.CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .rx(rx.slave), .clear(clear),
        .data_cnt(b_data), .ctrl_cnt(b_ctrl), .txer_cnt(b_txer), .mism_cnt(b_mism),
        .valid_cyc_cnt(b_valid), .lane_mism(b_lm), .link_state(b_ls), .fault(b_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: unbounded counts, saturation applied only when comparing.
    longint m_data, m_ctrl, m_txer, m_mism, m_valid;
    logic [7:0]  m_lm;
    int          m_state, m_err, m_good;
    logic [63:0] p_data;
    logic [7:0]  p_ctrl;
    logic        p_en, p_er;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic        en, er;
        int          reps;
        longint      e_data, e_ctrl, e_mism, e_txer, e_valid;
        logic [7:0]  e_lm;
        logic [1:0]  e_ls;
    } row_t;
    row_t tbl[$];

    function automatic longint sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [63:0] d, input logic [7:0] c,
                              input logic en, input logic er, input logic clr, input logic r);
        int nm, nc, ne, ng;
        logic bad, good;
        logic [7:0] lm;
        if (r || clr) begin
            m_data = 0; m_ctrl = 0; m_txer = 0; m_mism = 0; m_valid = 0;
            m_lm = 0; m_state = 0; m_err = 0; m_good = 0;
        end else begin
            nm = 0; nc = 0; lm = 0;
            for (int j = 0; j < 8; j++) begin
                if (p_ctrl[j]) nc++;
                if (p_data[8*j +: 8] != (p_ctrl[j] ? 8'h55 : 8'hAA)) begin
                    lm[j] = 1'b1;
                    nm++;
                end
            end
            if (p_en) begin
                m_ctrl += nc; m_data += 8 - nc; m_mism += nm; m_valid += 1;
            end
            if (p_er) m_txer += 1;
            m_lm = p_en ? lm : 8'h00;
            bad  = p_en && (p_er || nm > 0);
            good = p_en && !bad;
            ne = bad  ? ((m_err + 1 > ELIM) ? ELIM : m_err + 1) : 0;
            ng = good ? ((m_good + 1 > GLIM) ? GLIM : m_good + 1) : 0;
            case (m_state)
                0: if (p_en) m_state = (bad && ne >= ELIM) ? 2 : 1;
                1: if (bad && ne >= ELIM) m_state = 2; else if (!p_en) m_state = 0;
                2: if (good && ng >= GLIM) m_state = 1;
                default: m_state = 0;
            endcase
            m_err = ne; m_good = ng;
        end
        if (r) begin
            p_data = 0; p_ctrl = 0; p_en = 0; p_er = 0;
        end else begin
            p_data = d; p_ctrl = c; p_en = en && !clr; p_er = er;
        end
    endtask

    task automatic compare_all();
        chk("a_data_cnt", longint'(a_data), sat(m_data, 32));
        chk("a_ctrl_cnt", longint'(a_ctrl), sat(m_ctrl, 32));
        chk("a_txer_cnt", longint'(a_txer), sat(m_txer, 32));
        chk("a_mism_cnt", longint'(a_mism), sat(m_mism, 32));
        chk("a_valid_cnt", longint'(a_valid), sat(m_valid, 32));
        chk("a_lane_mism", longint'(a_lm), longint'(m_lm));
        chk("a_link_state", longint'(a_ls), longint'(m_state));
        chk("a_fault", longint'(a_fault), longint'(m_state == 2));
        chk("b_data_cnt", longint'(b_data), sat(m_data, 8));
        chk("b_ctrl_cnt", longint'(b_ctrl), sat(m_ctrl, 8));
        chk("b_txer_cnt", longint'(b_txer), sat(m_txer, 8));
        chk("b_mism_cnt", longint'(b_mism), sat(m_mism, 8));
        chk("b_valid_cnt", longint'(b_valid), sat(m_valid, 8));
        chk("b_lane_mism", longint'(b_lm), longint'(m_lm));
        chk("b_link_state", longint'(b_ls), longint'(m_state));
    endtask

    task automatic tick(input logic [63:0] d, input logic [7:0] c,
                        input logic en, input logic er, input logic clr, input logic r);
        rx.data_in = d; rx.ctrl_in = c; rx.tx_en = en; rx.tx_er = er;
        clear = clr; rst = r;
        @(posedge clk);
        model_edge(d, c, en, er, clr, r);
        #1;
        compare_all();
    endtask

    task automatic idle();
        tick(64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic void add_row(input logic [63:0] d, input logic [7:0] c,
                                    input logic en, input logic er, input int reps,
                                    input longint ed, input longint ec, input longint em,
                                    input longint et, input longint ev,
                                    input logic [7:0] lm, input logic [1:0] ls);
        row_t t;
        t.data = d; t.ctrl = c; t.en = en; t.er = er; t.reps = reps;
        t.e_data = ed; t.e_ctrl = ec; t.e_mism = em; t.e_txer = et; t.e_valid = ev;
        t.e_lm = lm; t.e_ls = ls;
        tbl.push_back(t);
    endfunction

    task automatic check_row(input int i);
        chk($sformatf("row%0d_data_cnt", i), longint'(a_data), tbl[i].e_data);
        chk($sformatf("row%0d_ctrl_cnt", i), longint'(a_ctrl), tbl[i].e_ctrl);
        chk($sformatf("row%0d_mism_cnt", i), longint'(a_mism), tbl[i].e_mism);
        chk($sformatf("row%0d_txer_cnt", i), longint'(a_txer), tbl[i].e_txer);
        chk($sformatf("row%0d_valid_cnt", i), longint'(a_valid), tbl[i].e_valid);
        chk($sformatf("row%0d_lane_mism", i), longint'(a_lm), longint'(tbl[i].e_lm));
        chk($sformatf("row%0d_link_state", i), longint'(a_ls), longint'(tbl[i].e_ls));
        chk($sformatf("row%0d_fault", i), longint'(a_fault), longint'(tbl[i].e_ls == 2'b10));
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        rst = 1'b1; clear = 1'b0;
        rx.data_in = '0; rx.ctrl_in = '0; rx.tx_en = 1'b0; rx.tx_er = 1'b0;
        m_data = 0; m_ctrl = 0; m_txer = 0; m_mism = 0; m_valid = 0;
        m_lm = 0; m_state = 0; m_err = 0; m_good = 0;
        p_data = 0; p_ctrl = 0; p_en = 0; p_er = 0;

        tick(64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_data_cnt", longint'(a_data), 0);
        chk("reset_link_state", longint'(a_ls), 0);
        chk("reset_fault", longint'(a_fault), 0);

        //      data    ctrl  en    er    reps data ctrl mism txer valid lm     state
        add_row(PAT_A,  8'h0F, 1'b1, 1'b0, 10,  40,  40,  0,   0,  10, 8'h00, 2'b01);
        add_row(ALL_AA, 8'h01, 1'b1, 1'b0, 1,   47,  41,  1,   0,  11, 8'h01, 2'b01);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b0, 1,   51,  45,  1,   0,  12, 8'h00, 2'b01);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b1, 3,   63,  57,  1,   3,  15, 8'h00, 2'b01);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b0, 1,   67,  61,  1,   3,  16, 8'h00, 2'b01);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b1, 4,   83,  77,  1,   7,  20, 8'h00, 2'b10);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b0, 7,  111, 105,  1,   7,  27, 8'h00, 2'b10);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b0, 1,  115, 109,  1,   7,  28, 8'h00, 2'b01);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b1, 4,  131, 125,  1,  11,  32, 8'h00, 2'b10);
        add_row(PAT_A,  8'h0F, 1'b0, 1'b1, 5,  131, 125,  1,  16,  32, 8'h00, 2'b10);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b0, 3,  143, 137,  1,  16,  35, 8'h00, 2'b10);
        add_row(PAT_A,  8'h0F, 1'b0, 1'b0, 1,  143, 137,  1,  16,  35, 8'h00, 2'b10);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b0, 7,  171, 165,  1,  16,  42, 8'h00, 2'b10);
        add_row(PAT_A,  8'h0F, 1'b1, 1'b0, 1,  175, 169,  1,  16,  43, 8'h00, 2'b01);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                tick(tbl[i].data, tbl[i].ctrl, tbl[i].en, tbl[i].er, 1'b0, 1'b0);
                if (r == 0 && i > 0) check_row(i - 1);
            end
        end
        idle();
        check_row(tbl.size() - 1);

        // Saturation on the 8-bit instance from a fresh reset.
        tick(64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) tick(ALL_AA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("sat_b_data_cnt", longint'(b_data), 255);
        chk("sat_b_valid_cnt", longint'(b_valid), 40);
        chk("sat_a_data_cnt", longint'(a_data), 320);
        idle();
        chk("sat_b_data_hold", longint'(b_data), 255);

        // Clear on the edge where a mismatching valid cycle sits in stage 1.
        tick(64'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(64'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_data_cnt", longint'(a_data), 0);
        chk("clr_mism_cnt", longint'(a_mism), 0);
        chk("clr_lane_mism", longint'(a_lm), 0);
        chk("clr_link_state", longint'(a_ls), 0);
        idle();
        chk("clr_after_mism_cnt", longint'(a_mism), 0);
        chk("clr_after_valid_cnt", longint'(a_valid), 0);
        chk("clr_after_link_state", longint'(a_ls), 0);

        // Reset out of FAULT.
        for (int k = 0; k < 4; k++) tick(PAT_A, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk("pre_rst_fault", longint'(a_fault), 1);
        tick(PAT_A, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_fault", longint'(a_fault), 0);
        chk("rst_link_state", longint'(a_ls), 0);
        chk("rst_txer_cnt", longint'(a_txer), 0);

        for (int k = 0; k < 600; k++) begin
            c = 8'($urandom);
            for (int j = 0; j < 8; j++) begin
                d[8*j +: 8] = c[j] ? 8'h55 : 8'hAA;
                if ($urandom_range(0, 15) == 0) d[8*j +: 8] = 8'($urandom);
            end
            tick(d, c, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
